// File: rtl/instr_prefetch_queue_if.sv
// rtl/instr_prefetch_queue_if.sv - fetch bus bundle: instruction memory, redirect and core handshake
interface instr_prefetch_queue_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [ADDR_W-1:0] IMEM_ADDR;
  logic              IMEM_RD_EN;
  logic [DATA_W-1:0] IMEM_DATA;
  logic              FLUSH;
  logic [ADDR_W-1:0] FLUSH_PC;
  logic              OUT_VALID;
  logic              OUT_READY;
  logic [DATA_W-1:0] OUT_INSTR;
  logic [ADDR_W-1:0] OUT_PC;
  logic [CW-1:0]     COUNT;

  // Prefetch queue side
  modport master (
    output IMEM_ADDR, IMEM_RD_EN, OUT_VALID, OUT_INSTR, OUT_PC, COUNT,
    input  IMEM_DATA, FLUSH, FLUSH_PC, OUT_READY
  );

  // Memory / core side
  modport slave (
    input  IMEM_ADDR, IMEM_RD_EN, OUT_VALID, OUT_INSTR, OUT_PC, COUNT,
    output IMEM_DATA, FLUSH, FLUSH_PC, OUT_READY
  );
endinterface

// File: rtl/instr_prefetch_queue.sv
// rtl/instr_prefetch_queue.sv - fetch PC owner and {PC, instr} prefetch FIFO with redirect flush
module instr_prefetch_queue #(
  parameter int              ADDR_W   = 32,
  parameter int              DATA_W   = 32,
  parameter int              DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h0040_0000
) (
  input logic                    CLK,
  input logic                    RST,
  instr_prefetch_queue_if.master bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {FETCH, STALL} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] fpc_q, fpc_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [ADDR_W-1:0] pc_mem    [DEPTH];
  logic [DATA_W-1:0] instr_mem [DEPTH];
  logic              pop;
  logic              push;
  logic              not_empty;

  // Handshake qualifiers; a full queue may still push when the head leaves this cycle
  always_comb begin
    not_empty = (count_q != '0);
    pop       = not_empty & bus.OUT_READY;
    push      = !RST & !bus.FLUSH & ((count_q < CW'(DEPTH)) | pop);
  end

  // Next PC, pointers and occupancy; a redirect empties the queue and wins over push
  always_comb begin
    fpc_d    = fpc_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (bus.FLUSH) begin
      // Masking keeps the target word-aligned regardless of the low two bits
      fpc_d    = bus.FLUSH_PC & ~ADDR_W'(3);
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
        fpc_d    = fpc_q + ADDR_W'(4);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Debug state: STALL marks a full queue that the core is not draining
  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH: if (!bus.FLUSH && count_d == CW'(DEPTH) && !pop) state_d = STALL;
      STALL: if (!(pop || bus.FLUSH)) state_d = STALL;
      default: state_d = FETCH;
    endcase
  end

  // Control registers with synchronous reset
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= FETCH;
      fpc_q    <= RESET_PC;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      fpc_q    <= fpc_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are only meaningful below the occupancy count
  always_ff @(posedge CLK) begin
    if (push) begin
      pc_mem[wr_ptr_q]    <= fpc_q;
      instr_mem[wr_ptr_q] <= bus.IMEM_DATA;
    end
  end

  assign bus.IMEM_ADDR  = fpc_q;
  assign bus.IMEM_RD_EN = push;
  assign bus.OUT_VALID  = not_empty;
  assign bus.OUT_INSTR  = not_empty ? instr_mem[rd_ptr_q] : '0;
  assign bus.OUT_PC     = not_empty ? pc_mem[rd_ptr_q] : '0;
  assign bus.COUNT      = count_q;
endmodule

// File: tb/tb_instr_prefetch_queue.sv
// tb/tb_instr_prefetch_queue.sv - directed bench for instr_prefetch_queue
module tb_instr_prefetch_queue;
  logic CLK;
  logic RST;
  int   tests;
  int   fails;

  instr_prefetch_queue_if #(.ADDR_W(32), .DATA_W(32), .DEPTH(4)) bus ();

  instr_prefetch_queue #(
    .ADDR_W(32), .DATA_W(32), .DEPTH(4), .RESET_PC(32'h0040_0000)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  // Instruction memory model: each word holds its own address
  assign bus.IMEM_DATA = bus.IMEM_ADDR;

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // One clock edge, then settle at the falling edge where inputs change and outputs are sampled
  task automatic step();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    CLK = 1'b0;
    RST = 1'b1;
    bus.FLUSH = 1'b0;
    bus.FLUSH_PC = 32'h0;
    bus.OUT_READY = 1'b1;
    step();
    step();

    // Reset state
    chk("rst_count", 32'(bus.COUNT), 32'd0);
    chk("rst_valid", 32'(bus.OUT_VALID), 32'd0);
    chk("rst_addr", bus.IMEM_ADDR, 32'h0040_0000);
    chk("rst_rden", 32'(bus.IMEM_RD_EN), 32'd0);
    chk("rst_pc_zero", bus.OUT_PC, 32'h0);
    chk("rst_instr_zero", bus.OUT_INSTR, 32'h0);

    // Streaming with core always ready; empty-queue ready is ignored
    RST = 1'b0;
    #1;
    chk("s1_rden_first", 32'(bus.IMEM_RD_EN), 32'd1);
    step();
    for (int k = 0; k < 5; k++) begin
      chk("s1_valid", 32'(bus.OUT_VALID), 32'd1);
      chk("s1_pc", bus.OUT_PC, 32'h0040_0000 + 32'(4 * k));
      chk("s1_instr", bus.OUT_INSTR, 32'h0040_0000 + 32'(4 * k));
      chk("s1_count", 32'(bus.COUNT), 32'd1);
      step();
    end

    // Back-pressure: queue fills and fetch stops
    RST = 1'b1;
    bus.OUT_READY = 1'b0;
    step();
    RST = 1'b0;
    for (int k = 0; k < 10; k++) step();
    chk("s2_count_full", 32'(bus.COUNT), 32'd4);
    chk("s2_rden_off", 32'(bus.IMEM_RD_EN), 32'd0);
    chk("s2_fpc_hold", bus.IMEM_ADDR, 32'h0040_0010);
    chk("s2_head", bus.OUT_PC, 32'h0040_0000);

    // Drain while full: push and pop every cycle, order preserved
    bus.OUT_READY = 1'b1;
    #1;
    chk("s3_rden_full_pop", 32'(bus.IMEM_RD_EN), 32'd1);
    for (int k = 0; k < 6; k++) begin
      chk("s3_pc", bus.OUT_PC, 32'h0040_0000 + 32'(4 * k));
      chk("s3_count", 32'(bus.COUNT), 32'd4);
      step();
    end

    // Flush with misaligned target while three entries pending
    RST = 1'b1;
    bus.OUT_READY = 1'b0;
    step();
    RST = 1'b0;
    step();
    step();
    step();
    chk("s4_count3", 32'(bus.COUNT), 32'd3);
    bus.FLUSH = 1'b1;
    bus.FLUSH_PC = 32'h0040_0043;
    #1;
    chk("s4_rden_flush", 32'(bus.IMEM_RD_EN), 32'd0);
    step();
    bus.FLUSH = 1'b0;
    bus.OUT_READY = 1'b1;
    chk("s4_count0", 32'(bus.COUNT), 32'd0);
    chk("s4_valid0", 32'(bus.OUT_VALID), 32'd0);
    chk("s4_addr", bus.IMEM_ADDR, 32'h0040_0040);
    step();
    chk("s4_out_pc", bus.OUT_PC, 32'h0040_0040);
    chk("s4_out_instr", bus.OUT_INSTR, 32'h0040_0040);
    chk("s4_count1", 32'(bus.COUNT), 32'd1);

    // Fetch PC wrap at top of address space
    bus.FLUSH = 1'b1;
    bus.FLUSH_PC = 32'hFFFF_FFFE;
    step();
    bus.FLUSH = 1'b0;
    chk("s5_addr_top", bus.IMEM_ADDR, 32'hFFFF_FFFC);
    step();
    chk("s5_pc_top", bus.OUT_PC, 32'hFFFF_FFFC);
    chk("s5_addr_wrap", bus.IMEM_ADDR, 32'h0000_0000);
    step();
    chk("s5_pc_wrap", bus.OUT_PC, 32'h0000_0000);
    chk("s5_valid", 32'(bus.OUT_VALID), 32'd1);

    // Back-to-back flushes: last target wins, queue stays empty
    bus.OUT_READY = 1'b0;
    bus.FLUSH = 1'b1;
    bus.FLUSH_PC = 32'h0000_1000;
    step();
    bus.FLUSH_PC = 32'h0000_2000;
    chk("s7_count_mid", 32'(bus.COUNT), 32'd0);
    step();
    bus.FLUSH = 1'b0;
    chk("s7_addr_last", bus.IMEM_ADDR, 32'h0000_2000);
    chk("s7_count", 32'(bus.COUNT), 32'd0);
    step();
    step();
    chk("s6_count2", 32'(bus.COUNT), 32'd2);
    chk("s6_head", bus.OUT_PC, 32'h0000_2000);

    // Reset pulse mid-stream drops pending entries
    RST = 1'b1;
    #1;
    chk("s6_rden_rst", 32'(bus.IMEM_RD_EN), 32'd0);
    step();
    RST = 1'b0;
    chk("s6_valid0", 32'(bus.OUT_VALID), 32'd0);
    chk("s6_count0", 32'(bus.COUNT), 32'd0);
    chk("s6_addr", bus.IMEM_ADDR, 32'h0040_0000);
    step();
    chk("s6_resume_pc", bus.OUT_PC, 32'h0040_0000);
    chk("s6_resume_cnt", 32'(bus.COUNT), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
